// File: rtl/alu_issue_stage_if.sv
// Bundle between the issue stage, its requester, its result consumer and the external ALU.
// Latency: none, wires only.
// Backpressure: carried by in_valid/in_ready and out_valid/out_ready.
interface alu_issue_stage_if;
    // request side
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_use_cin;

    // one-hot controls to the ALU
    logic        B15to0;
    logic        AandB;
    logic        AorB;
    logic        notB;
    logic        shlB;
    logic        shrB;
    logic        AaddB;
    logic        AsubB;
    logic        AmulB;
    logic        AcmpB;

    // operands to the ALU and its response
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [15:0] aluout;
    logic        cout;
    logic        zout;

    // result side
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_err;

    // architectural flags
    logic        cflag;
    logic        zflag;

    // the issue stage itself
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_use_cin,
        input  aluout, cout, zout,
        input  out_ready,
        output in_ready,
        output B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB,
        output alu_a, alu_b, alu_cin,
        output out_valid, out_result, out_err,
        output cflag, zflag
    );

    // requester, consumer and ALU seen from outside the stage
    modport master (
        output in_valid, in_op, in_a, in_b, in_use_cin,
        output aluout, cout, zout,
        output out_ready,
        input  in_ready,
        input  B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB,
        input  alu_a, alu_b, alu_cin,
        input  out_valid, out_result, out_err,
        input  cflag, zflag
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issues one request at a time to an external one-hot ALU, owns the carry/zero flags, returns the result.
// Latency: accept cycle, one EXEC cycle, out_valid high in the following DONE cycle.
// Backpressure: DONE holds a stable result until out_ready; in_ready only in IDLE, so one request per 3 cycles at best.
module alu_issue_stage (
    input  logic             clk,
    input  logic             ExternalReset,
    alu_issue_stage_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_LAST_ALU = 4'd9;
    localparam logic [3:0] OP_CLRC = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRZ = 4'd12;
    localparam logic [3:0] OP_SETZ = 4'd13;

    logic [1:0]  state;
    logic [3:0]  held_op;
    logic [15:0] held_a;
    logic [15:0] held_b;
    logic        held_use_cin;
    logic        cflag_reg;
    logic        zflag_reg;
    logic [15:0] result_reg;
    logic        err_reg;
    logic [9:0]  ctl;

    logic        accept;
    logic        in_exec;
    logic        alu_op;
    logic        carry_in_op;
    logic        carry_out_op;

    assign accept       = (state == IDLE) && bus.in_valid;
    assign in_exec      = (state == EXEC);
    assign alu_op       = (held_op <= OP_LAST_ALU);
    // only add and subtract consume the carry flag
    assign carry_in_op  = (held_op == OP_ADD) || (held_op == OP_SUB);
    // compare also reports through the carry, other ALU ops leave it alone
    assign carry_out_op = carry_in_op || (held_op == OP_CMP);

    // IDLE -> EXEC on accept, EXEC -> DONE always, DONE -> IDLE once the consumer takes the result
    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= EXEC;
                EXEC:    state <= DONE;
                DONE:    if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the request so the requester may change its inputs right after the handshake
    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            held_op      <= '0;
            held_a       <= '0;
            held_b       <= '0;
            held_use_cin <= 1'b0;
        end else if (accept) begin
            held_op      <= bus.in_op;
            held_a       <= bus.in_a;
            held_b       <= bus.in_b;
            held_use_cin <= bus.in_use_cin;
        end
    end

    // Result and error are written only on the EXEC -> DONE edge, so they stay frozen while stalled
    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else if (in_exec) begin
            if (alu_op) begin
                result_reg <= bus.aluout;
                err_reg    <= 1'b0;
            end else if (held_op <= OP_SETZ) begin
                result_reg <= '0;
                err_reg    <= 1'b0;
            end else begin
                result_reg <= '0;
                err_reg    <= 1'b1;
            end
        end
    end

    // Flags change once per request at the EXEC -> DONE edge; illegal ops touch nothing
    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            cflag_reg <= 1'b0;
            zflag_reg <= 1'b0;
        end else if (in_exec) begin
            if (alu_op) begin
                zflag_reg <= bus.zout;
                if (carry_out_op) begin
                    cflag_reg <= bus.cout;
                end
            end else begin
                case (held_op)
                    OP_CLRC: cflag_reg <= 1'b0;
                    OP_SETC: cflag_reg <= 1'b1;
                    OP_CLRZ: zflag_reg <= 1'b0;
                    OP_SETZ: zflag_reg <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // One-hot ALU select, live only while executing a real ALU op
    always_comb begin
        ctl = '0;
        if (in_exec && alu_op) begin
            ctl = 10'd1 << held_op;
        end
    end

    assign bus.B15to0 = ctl[0];
    assign bus.AandB  = ctl[1];
    assign bus.AorB   = ctl[2];
    assign bus.notB   = ctl[3];
    assign bus.shlB   = ctl[4];
    assign bus.shrB   = ctl[5];
    assign bus.AaddB  = ctl[6];
    assign bus.AsubB  = ctl[7];
    assign bus.AmulB  = ctl[8];
    assign bus.AcmpB  = ctl[9];

    // Operands are presented only during EXEC so the ALU sees zeros while idle
    assign bus.alu_a   = in_exec ? held_a : 16'd0;
    assign bus.alu_b   = in_exec ? held_b : 16'd0;
    assign bus.alu_cin = in_exec && carry_in_op && held_use_cin && cflag_reg;

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result_reg;
    assign bus.out_err    = err_reg;
    assign bus.cflag      = cflag_reg;
    assign bus.zflag      = zflag_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage with an ALU model and an op-level reference model.
// Latency: checks EXEC one cycle after accept and DONE the cycle after that.
// Backpressure: stalls DONE for a random number of cycles while poking in_valid.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic ExternalReset;

    alu_issue_stage_if bus();

    alu_issue_stage dut (
        .clk           (clk),
        .ExternalReset (ExternalReset),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference copy of the architectural flags
    logic mc;
    logic mz;

    logic [9:0]  ctl_seen;
    logic [16:0] alu_w;
    logic [16:0] alu_d;

    assign ctl_seen = {bus.AcmpB, bus.AmulB, bus.AsubB, bus.AaddB, bus.shrB,
                       bus.shlB, bus.notB, bus.AorB, bus.AandB, bus.B15to0};

    // External ALU: combinational, selected purely by the one-hot controls
    always_comb begin
        alu_w = '0;
        alu_d = '0;
        case (ctl_seen)
            10'b0000000001: alu_w = {1'b0, bus.alu_b};
            10'b0000000010: alu_w = {1'b0, bus.alu_a & bus.alu_b};
            10'b0000000100: alu_w = {1'b0, bus.alu_a | bus.alu_b};
            10'b0000001000: alu_w = {1'b0, ~bus.alu_b};
            10'b0000010000: alu_w = {bus.alu_b[15], bus.alu_b[14:0], 1'b0};
            10'b0000100000: alu_w = {bus.alu_b[0], 1'b0, bus.alu_b[15:1]};
            10'b0001000000: alu_w = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_cin};
            10'b0010000000: begin
                alu_d = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {16'd0, bus.alu_cin};
                alu_w = {~alu_d[16], alu_d[15:0]};
            end
            10'b0100000000: alu_w = {1'b0, bus.alu_a * bus.alu_b};
            10'b1000000000: alu_w = {(bus.alu_a >= bus.alu_b), bus.alu_a};
            default:        alu_w = '0;
        endcase
    end

    assign bus.aluout = alu_w[15:0];
    assign bus.cout   = alu_w[16];
    assign bus.zout   = (alu_w[15:0] == 16'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Architectural meaning of each op, written directly from the op table
    task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic uc, input logic c_in, input logic z_in,
                             output logic [15:0] r, output logic e,
                             output logic c_out, output logic z_out);
        int unsigned s;
        int          d;
        int unsigned cin;
        cin   = (uc && c_in && (op == 4'd6 || op == 4'd7)) ? 1 : 0;
        r     = 16'd0;
        e     = 1'b0;
        c_out = c_in;
        z_out = z_in;
        case (op)
            4'd0: r = b;
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = ~b;
            4'd4: r = b << 1;
            4'd5: r = b >> 1;
            4'd6: begin
                s = 32'(a) + 32'(b) + cin;
                r = s[15:0];
                c_out = (s > 32'd65535);
            end
            4'd7: begin
                d = int'(a) - int'(b) - int'(cin);
                r = d[15:0];
                c_out = (d >= 0);
            end
            4'd8: begin
                s = 32'(a) * 32'(b);
                r = s[15:0];
            end
            4'd9: begin
                r = a;
                c_out = (a >= b);
            end
            4'd10: c_out = 1'b0;
            4'd11: c_out = 1'b1;
            4'd12: z_out = 1'b0;
            4'd13: z_out = 1'b1;
            default: e = 1'b1;
        endcase
        if (op <= 4'd9) z_out = (r == 16'd0);
    endtask

    // One complete request: accept, EXEC checks, DONE with `stall` cycles of back-pressure, return to IDLE
    task automatic run_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic uc, input int stall);
        logic [15:0] er;
        logic        ee, ec, ez, ecin;
        logic [9:0]  ectl;
        ref_model(op, a, b, uc, mc, mz, er, ee, ec, ez);
        ecin = uc && mc && (op == 4'd6 || op == 4'd7);
        ectl = (op <= 4'd9) ? (10'd1 << op) : 10'd0;

        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_ctl", ctl_seen, 0);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_use_cin = uc;
        @(posedge clk); #1;

        // EXEC: scramble the request inputs, they must already be registered
        bus.in_valid   = 1'($urandom_range(0, 1));
        bus.in_op      = 4'($urandom);
        bus.in_a       = 16'($urandom);
        bus.in_b       = 16'($urandom);
        bus.in_use_cin = 1'($urandom_range(0, 1));
        chk("exec_in_ready", bus.in_ready, 0);
        chk("exec_out_valid", bus.out_valid, 0);
        chk("exec_ctl", ctl_seen, ectl);
        chk("exec_alu_a", bus.alu_a, a);
        chk("exec_alu_b", bus.alu_b, b);
        chk("exec_alu_cin", bus.alu_cin, ecin);
        chk("exec_cflag_old", bus.cflag, mc);
        chk("exec_zflag_old", bus.zflag, mz);
        @(posedge clk); #1;

        mc = ec;
        mz = ez;
        for (int i = 0; i <= stall; i++) begin
            chk("done_out_valid", bus.out_valid, 1);
            chk("done_result", bus.out_result, er);
            chk("done_err", bus.out_err, ee);
            chk("done_cflag", bus.cflag, mc);
            chk("done_zflag", bus.zflag, mz);
            chk("done_in_ready", bus.in_ready, 0);
            chk("done_ctl", ctl_seen, 0);
            chk("done_alu_ab", {bus.alu_a, bus.alu_b}, 0);
            chk("done_alu_cin", bus.alu_cin, 0);
            bus.out_ready = (i == stall);
            bus.in_valid  = (i == stall) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.in_op     = 4'($urandom);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        chk("back_out_valid", bus.out_valid, 0);
        chk("back_in_ready", bus.in_ready, 1);
        chk("back_result_hold", bus.out_result, er);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_result"}, bus.out_result, 0);
        chk({tag, "_err"}, bus.out_err, 0);
        chk({tag, "_flags"}, {bus.cflag, bus.zflag}, 0);
        chk({tag, "_ctl"}, ctl_seen, 0);
        chk({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 0);
        chk({tag, "_alu_cin"}, bus.alu_cin, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          pick;
        ExternalReset  = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_use_cin = 1'b0;
        bus.out_ready  = 1'b0;
        mc = 1'b0;
        mz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        ExternalReset = 1'b0;
        chk("rst_release_in_ready", bus.in_ready, 1);

        // carry-in add wrapping to zero
        run_req(4'd11, 16'h1234, 16'h5678, 1'b0, 0);
        run_req(4'd6, 16'hFFFF, 16'h0000, 1'b1, 0);
        chk("add_wrap_result", bus.out_result, 16'h0000);
        chk("add_wrap_flags", {bus.cflag, bus.zflag}, 2'b11);

        // compare
        run_req(4'd9, 16'h0005, 16'h0003, 1'b0, 0);
        chk("cmp_result", bus.out_result, 16'h0005);
        chk("cmp_flags", {bus.cflag, bus.zflag}, 2'b10);

        // long back-pressure on an AND
        run_req(4'd1, 16'h00F0, 16'h0FF0, 1'b0, 5);
        chk("and_result", bus.out_result, 16'h00F0);

        // flag ops
        run_req(4'd12, 16'hAAAA, 16'h5555, 1'b1, 0);
        run_req(4'd11, 16'hAAAA, 16'h5555, 1'b1, 0);
        chk("setc_flags", {bus.cflag, bus.zflag}, 2'b10);
        run_req(4'd13, 16'hAAAA, 16'h5555, 1'b1, 1);
        chk("setz_flags", {bus.cflag, bus.zflag}, 2'b11);
        run_req(4'd10, 16'hAAAA, 16'h5555, 1'b1, 0);
        chk("clrc_flags", {bus.cflag, bus.zflag}, 2'b01);

        // illegal op then a legal one
        run_req(4'd15, 16'h1111, 16'h2222, 1'b0, 2);
        chk("illegal_flags", {bus.cflag, bus.zflag}, 2'b01);
        run_req(4'd2, 16'h1100, 16'h0022, 1'b0, 0);
        chk("legal_after_illegal_err", bus.out_err, 0);
        chk("legal_after_illegal_result", bus.out_result, 16'h1122);

        // reset while a notB is in EXEC
        run_req(4'd11, 16'h0, 16'h0, 1'b0, 0);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'd3;
        bus.in_a     = 16'h0F0F;
        bus.in_b     = 16'h00FF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("abort_exec_ctl", ctl_seen, 10'b0000001000);
        ExternalReset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("abort");
        ExternalReset = 1'b0;
        mc = 1'b0;
        mz = 1'b0;
        chk("abort_release_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        chk("abort_no_late_valid", bus.out_valid, 0);
        chk("abort_flags_after", {bus.cflag, bus.zflag}, 0);

        // random traffic
        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 7);
            ra = (pick == 0) ? 16'hFFFF : (pick == 1) ? 16'h0000 : 16'($urandom);
            pick = $urandom_range(0, 7);
            rb = (pick == 0) ? 16'hFFFF : (pick == 1) ? 16'h0000 : (pick == 2) ? ra : 16'($urandom);
            run_req(4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
